stall_ctrl: RTL and testbench
=============================

STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4: multiplier latency in cycles (legal range 2..15).
REQ-002 cpu_clk_50M  input  1  Sole clock; all state updates on its rising edge.
REQ-003 cpu_rst_n  input  1  Reset, asynchronous, active-low.
REQ-004 id_valid  input  1  ID stage holds a valid instruction.
REQ-005 id_rreg1 / id_rreg2  input  1 each  ID regfile read enables for ports 1 and 2.
REQ-006 id_ra1 / id_ra2  input  5 each  ID regfile read addresses for ports 1 and 2.
REQ-007 id_mult  input  1  Instruction in ID is MULT (writes HI/LO).
REQ-008 id_mfhilo  input  1  Instruction in ID is MFHI or MFLO.
REQ-009 ex_mreg  input  1  Instruction in EX is a load.
REQ-010 ex_wreg  input  1  Instruction in EX writes a GPR.
REQ-011 ex_wa  input  5  GPR destination address of the instruction in EX.
REQ-012 perf_clr  input  1  Synchronous clear of stall_cnt.
REQ-013 stall_if  output  1  Hold PC and the IF/ID register.
REQ-014 stall_id  output  1  Hold the ID stage.
REQ-015 bubble_ex  output  1  Load NOP (all-zero control) into ID/EX this cycle.
REQ-016 mul_start  output  1  One-cycle pulse; starts the multiplier with the EX operands.
REQ-017 mul_done  output  1  Multiplier result valid; HI/LO write enable.
REQ-018 mul_busy  output  1  Multiplier occupied (state not IDLE).
REQ-019 stall_cnt  output  16  Saturating count of cycles with stall_id=1.

Function
REQ-020 The FSM SHALL have states IDLE, BUSY and DRAIN, plus a 4-bit down-counter cnt.
REQ-021 load_hz SHALL equal id_valid & ex_mreg & ex_wreg & (ex_wa!=0) & ((id_rreg1 & id_ra1==ex_wa) | (id_rreg2 & id_ra2==ex_wa)).
REQ-022 hilo_hz SHALL equal id_valid & (id_mult | id_mfhilo) & (state!=IDLE).
REQ-023 stall_if, stall_id and bubble_ex SHALL each equal load_hz | hilo_hz, combinationally, in the same cycle.
REQ-024 A MULT is accepted on an edge with id_valid & id_mult & state==IDLE & !load_hz.
REQ-025 On acceptance: state <= BUSY, cnt <= MUL_CYCLES-1, and mul_start is registered 1 for exactly the next cycle (the MULT is then in EX).
REQ-026 In BUSY, cnt SHALL decrement by 1 per cycle, and the FSM SHALL move to DRAIN on the edge where cnt==1.
REQ-027 In DRAIN, mul_done=1 for exactly one cycle, then state <= IDLE.
REQ-028 Start-to-done timing: mul_done SHALL be asserted exactly MUL_CYCLES-1 cycles after the mul_start cycle; total occupancy (mul_busy high) is MUL_CYCLES cycles.
REQ-029 A MULT or MFHI/MFLO in ID during DRAIN SHALL stall; it proceeds in the first IDLE cycle, after the HI/LO write.
REQ-030 While mul_busy=1, instructions other than MULT, MFHI and MFLO SHALL flow without stall unless load_hz.
REQ-031 When load_hz and hilo_hz are both true, a single stall SHALL be applied; the FSM still advances.
REQ-032 stall_cnt SHALL increment when stall_id=1 and SHALL saturate at 16'hFFFF.
REQ-033 perf_clr SHALL take priority over increment; the cleared value is 0 even if stall_id=1 in that cycle.
REQ-034 Load hazards against register 0 SHALL never stall.

Reset
REQ-035 While cpu_rst_n=0, regardless of the clock: state=IDLE, cnt=0, mul_start=0, mul_done=0, mul_busy=0, stall_cnt=0.
REQ-036 While cpu_rst_n=0, stall_if, stall_id and bubble_ex SHALL be forced to 0.
REQ-037 Reset asserted mid-multiply SHALL abort it: no mul_done pulse follows, and the block restarts in IDLE.

Verification
REQ-038 Load-use: EX lw writing $5 (ex_mreg=1, ex_wreg=1, ex_wa=5); ID has id_rreg2=1, id_ra2=5 -> stall_if, stall_id and bubble_ex are 1 for that cycle; stall_cnt becomes 1.
REQ-039 Zero register: same as REQ-038 but ex_wa=0 and id_ra2=0 -> no stall; stall_cnt stays 0.
REQ-040 MULT then MFLO, MUL_CYCLES=4 -> mul_start in cycle t, mul_done in t+3, mul_busy in t..t+3; MFLO stalls while busy and enters EX at t+4.
REQ-041 MULT then independent ADDU -> the ADDU passes without stall while mul_busy=1.
REQ-042 MULT accepted, then cpu_rst_n=0 at t+1 -> all outputs 0 immediately; no mul_done after release; next MULT restarts timing from mul_start.
REQ-043 Saturation: force 70000 consecutive stall cycles -> stall_cnt holds 16'hFFFF; one perf_clr cycle -> 0.

Source files
------------

// File: rtl/stall_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: ID/EX hazard inputs, stall/bubble
// controls, multiplier handshake and the stall performance counter.
interface stall_ctrl_if;
   logic        id_valid;
   logic        id_rreg1;
   logic        id_rreg2;
   logic [4:0]  id_ra1;
   logic [4:0]  id_ra2;
   logic        id_mult;
   logic        id_mfhilo;
   logic        ex_mreg;
   logic        ex_wreg;
   logic [4:0]  ex_wa;
   logic        perf_clr;
   logic        stall_if;
   logic        stall_id;
   logic        bubble_ex;
   logic        mul_start;
   logic        mul_done;
   logic        mul_busy;
   logic [15:0] stall_cnt;

   modport master (
      output id_valid, id_rreg1, id_rreg2, id_ra1, id_ra2, id_mult, id_mfhilo,
      output ex_mreg, ex_wreg, ex_wa, perf_clr,
      input  stall_if, stall_id, bubble_ex, mul_start, mul_done, mul_busy, stall_cnt
   );

   modport slave (
      input  id_valid, id_rreg1, id_rreg2, id_ra1, id_ra2, id_mult, id_mfhilo,
      input  ex_mreg, ex_wreg, ex_wa, perf_clr,
      output stall_if, stall_id, bubble_ex, mul_start, mul_done, mul_busy, stall_cnt
   );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: load-use hazard detection plus a fixed-latency
// multiplier sequencer that holds back HI/LO users until the result is written.
module stall_ctrl #(
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic         cpu_clk_50M,
   input  logic         cpu_rst_n,
   stall_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        mul_start_q;
   logic        mul_done_q;
   logic        mul_busy_q;
   logic [15:0] stall_cnt_q;
   logic [15:0] stall_cnt_d;

   logic ra1_hit;
   logic ra2_hit;
   logic load_hz;
   logic hilo_hz;
   logic stall;
   logic mul_accept;

   assign ra1_hit = bus.id_rreg1 && (bus.id_ra1 == bus.ex_wa);
   assign ra2_hit = bus.id_rreg2 && (bus.id_ra2 == bus.ex_wa);

   // $0 is hard-wired zero, so a load targeting it never produces a real dependency.
   assign load_hz = bus.id_valid && bus.ex_mreg && bus.ex_wreg &&
                    (bus.ex_wa != 5'd0) && (ra1_hit || ra2_hit);

   assign hilo_hz = bus.id_valid && (bus.id_mult || bus.id_mfhilo) && (state_q != IDLE);

   assign stall = (load_hz || hilo_hz) && cpu_rst_n;

   assign mul_accept = bus.id_valid && bus.id_mult && (state_q == IDLE) && !load_hz;

   assign bus.stall_if  = stall;
   assign bus.stall_id  = stall;
   assign bus.bubble_ex = stall;
   assign bus.mul_start = mul_start_q;
   assign bus.mul_done  = mul_done_q;
   assign bus.mul_busy  = mul_busy_q;
   assign bus.stall_cnt = stall_cnt_q;

   // Done is raised on the same edge that enters DRAIN so it lines up with that state.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         mul_start_q <= 1'b0;
         mul_done_q  <= 1'b0;
         mul_busy_q  <= 1'b0;
      end else begin
         mul_start_q <= 1'b0;
         mul_done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mul_accept) begin
                  state_q     <= BUSY;
                  cnt_q       <= CNT_INIT;
                  mul_start_q <= 1'b1;
                  mul_busy_q  <= 1'b1;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q    <= DRAIN;
                  mul_done_q <= 1'b1;
               end
            end
            DRAIN: begin
               state_q    <= IDLE;
               mul_busy_q <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               cnt_q      <= 4'd0;
               mul_busy_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (bus.perf_clr) begin
         stall_cnt_d = 16'd0;
      end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: load-use, $0 exemption, MULT/MFLO timing,
// independent flow under a busy multiplier, reset abort and counter saturation.
module tb_stall_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   stall_ctrl_if bus ();

   stall_ctrl #(.MUL_CYCLES(4)) dut (
      .cpu_clk_50M (clk),
      .cpu_rst_n   (rst_n),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.id_valid  = 1'b0;
      bus.id_rreg1  = 1'b0;
      bus.id_rreg2  = 1'b0;
      bus.id_ra1    = 5'd0;
      bus.id_ra2    = 5'd0;
      bus.id_mult   = 1'b0;
      bus.id_mfhilo = 1'b0;
      bus.ex_mreg   = 1'b0;
      bus.ex_wreg   = 1'b0;
      bus.ex_wa     = 5'd0;
      bus.perf_clr  = 1'b0;
   endtask

   task automatic drive_load_use();
      idle_inputs();
      bus.id_valid = 1'b1;
      bus.id_rreg2 = 1'b1;
      bus.id_ra2   = 5'd5;
      bus.ex_mreg  = 1'b1;
      bus.ex_wreg  = 1'b1;
      bus.ex_wa    = 5'd5;
   endtask

   task automatic drive_mult();
      idle_inputs();
      bus.id_valid = 1'b1;
      bus.id_mult  = 1'b1;
   endtask

   task automatic clear_counter();
      idle_inputs();
      bus.perf_clr = 1'b1;
      tick();
      bus.perf_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_load_use();
      #2;
      n_checks++;
      if (bus.stall_id !== 1'b0) begin
         n_errors++; $display("FAIL reset_stall_id: got %b expected 0", bus.stall_id);
      end
      n_checks++;
      if ({bus.stall_if, bus.bubble_ex} !== 2'b00) begin
         n_errors++; $display("FAIL reset_stall_if_bubble: got %b expected 00", {bus.stall_if, bus.bubble_ex});
      end
      tick();
      tick();
      n_checks++;
      if ({bus.mul_start, bus.mul_done, bus.mul_busy} !== 3'b000) begin
         n_errors++; $display("FAIL reset_mul_outputs: got %b expected 000", {bus.mul_start, bus.mul_done, bus.mul_busy});
      end
      n_checks++;
      if (bus.stall_cnt !== 16'd0) begin
         n_errors++; $display("FAIL reset_stall_cnt: got %h expected 0000", bus.stall_cnt);
      end
      idle_inputs();
      rst_n = 1'b1;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_load_use();
      clear_counter();
      drive_load_use();
      #1;
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.bubble_ex} !== 3'b111) begin
         n_errors++; $display("FAIL load_use_stall: got %b expected 111", {bus.stall_if, bus.stall_id, bus.bubble_ex});
      end
      tick();
      idle_inputs();
      #1;
      n_checks++;
      if (bus.stall_cnt !== 16'd1) begin
         n_errors++; $display("FAIL load_use_cnt: got %0d expected 1", bus.stall_cnt);
      end
      // Hazard through read port 1 instead of port 2.
      drive_load_use();
      bus.id_rreg2 = 1'b0;
      bus.id_rreg1 = 1'b1;
      bus.id_ra1   = 5'd5;
      #1;
      n_checks++;
      if (bus.stall_id !== 1'b1) begin
         n_errors++; $display("FAIL load_use_port1: got %b expected 1", bus.stall_id);
      end
      // A non-load writer in EX is forwarded, not stalled.
      bus.ex_mreg = 1'b0;
      #1;
      n_checks++;
      if (bus.stall_id !== 1'b0) begin
         n_errors++; $display("FAIL load_use_not_load: got %b expected 0", bus.stall_id);
      end
      // No valid instruction in ID means no hazard.
      drive_load_use();
      bus.id_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.stall_id !== 1'b0) begin
         n_errors++; $display("FAIL load_use_invalid_id: got %b expected 0", bus.stall_id);
      end
      idle_inputs();
      tick();
      $display("test_load_use done");
   endtask

   task automatic test_zero_reg();
      clear_counter();
      drive_load_use();
      bus.ex_wa  = 5'd0;
      bus.id_ra2 = 5'd0;
      #1;
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.bubble_ex} !== 3'b000) begin
         n_errors++; $display("FAIL zero_reg_stall: got %b expected 000", {bus.stall_if, bus.stall_id, bus.bubble_ex});
      end
      tick();
      idle_inputs();
      n_checks++;
      if (bus.stall_cnt !== 16'd0) begin
         n_errors++; $display("FAIL zero_reg_cnt: got %0d expected 0", bus.stall_cnt);
      end
      $display("test_zero_reg done");
   endtask

   task automatic test_mult_mflo();
      clear_counter();
      drive_mult();
      #1;
      n_checks++;
      if (bus.stall_id !== 1'b0) begin
         n_errors++; $display("FAIL mult_accept_stall: got %b expected 0", bus.stall_id);
      end
      tick();
      // Cycle t: MULT in EX, MFLO now in ID.
      idle_inputs();
      bus.id_valid  = 1'b1;
      bus.id_mfhilo = 1'b1;
      #1;
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (bus.mul_start !== (c == 0)) begin
            n_errors++; $display("FAIL mflo_mul_start_t%0d: got %b expected %b", c, bus.mul_start, (c == 0));
         end
         n_checks++;
         if (bus.mul_done !== (c == 3)) begin
            n_errors++; $display("FAIL mflo_mul_done_t%0d: got %b expected %b", c, bus.mul_done, (c == 3));
         end
         n_checks++;
         if (bus.mul_busy !== 1'b1) begin
            n_errors++; $display("FAIL mflo_mul_busy_t%0d: got %b expected 1", c, bus.mul_busy);
         end
         n_checks++;
         if (bus.stall_id !== 1'b1) begin
            n_errors++; $display("FAIL mflo_stall_t%0d: got %b expected 1", c, bus.stall_id);
         end
         tick();
      end
      // Cycle t+4: back in IDLE, MFLO proceeds.
      n_checks++;
      if ({bus.mul_busy, bus.mul_done, bus.stall_id} !== 3'b000) begin
         n_errors++; $display("FAIL mflo_release: got busy/done/stall %b expected 000", {bus.mul_busy, bus.mul_done, bus.stall_id});
      end
      n_checks++;
      if (bus.stall_cnt !== 16'd4) begin
         n_errors++; $display("FAIL mflo_stall_cnt: got %0d expected 4", bus.stall_cnt);
      end
      idle_inputs();
      tick();
      $display("test_mult_mflo done");
   endtask

   task automatic test_addu_and_dual();
      drive_mult();
      tick();
      // Cycle t: independent ADDU in ID.
      idle_inputs();
      bus.id_valid = 1'b1;
      bus.id_rreg1 = 1'b1;
      bus.id_ra1   = 5'd3;
      bus.id_rreg2 = 1'b1;
      bus.id_ra2   = 5'd4;
      #1;
      n_checks++;
      if ({bus.stall_id, bus.mul_busy} !== 2'b01) begin
         n_errors++; $display("FAIL addu_no_stall: got stall/busy %b expected 01", {bus.stall_id, bus.mul_busy});
      end
      tick();
      // Cycle t+1: MULT that also has a load-use hazard -> one stall.
      drive_load_use();
      bus.id_mult = 1'b1;
      #1;
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.bubble_ex} !== 3'b111) begin
         n_errors++; $display("FAIL dual_hazard_stall: got %b expected 111", {bus.stall_if, bus.stall_id, bus.bubble_ex});
      end
      tick();
      idle_inputs();
      n_checks++;
      if ({bus.mul_busy, bus.mul_done} !== 2'b10) begin
         n_errors++; $display("FAIL dual_t2: got busy/done %b expected 10", {bus.mul_busy, bus.mul_done});
      end
      tick();
      n_checks++;
      if ({bus.mul_busy, bus.mul_done} !== 2'b11) begin
         n_errors++; $display("FAIL dual_t3_done: got busy/done %b expected 11", {bus.mul_busy, bus.mul_done});
      end
      tick();
      n_checks++;
      if ({bus.mul_busy, bus.mul_done} !== 2'b00) begin
         n_errors++; $display("FAIL dual_t4_idle: got busy/done %b expected 00", {bus.mul_busy, bus.mul_done});
      end
      $display("test_addu_and_dual done");
   endtask

   task automatic test_reset_abort();
      drive_mult();
      tick();
      idle_inputs();
      n_checks++;
      if (bus.mul_start !== 1'b1) begin
         n_errors++; $display("FAIL abort_start: got %b expected 1", bus.mul_start);
      end
      tick();
      rst_n = 1'b0;
      drive_load_use();
      #1;
      n_checks++;
      if ({bus.mul_start, bus.mul_done, bus.mul_busy, bus.stall_id} !== 4'b0000) begin
         n_errors++; $display("FAIL abort_outputs: got %b expected 0000", {bus.mul_start, bus.mul_done, bus.mul_busy, bus.stall_id});
      end
      tick();
      tick();
      idle_inputs();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if ({bus.mul_done, bus.mul_busy} !== 2'b00) begin
            n_errors++; $display("FAIL abort_no_done_c%0d: got done/busy %b expected 00", c, {bus.mul_done, bus.mul_busy});
         end
      end
      drive_mult();
      tick();
      idle_inputs();
      n_checks++;
      if ({bus.mul_start, bus.mul_busy} !== 2'b11) begin
         n_errors++; $display("FAIL restart_start: got start/busy %b expected 11", {bus.mul_start, bus.mul_busy});
      end
      tick();
      tick();
      n_checks++;
      if (bus.mul_done !== 1'b0) begin
         n_errors++; $display("FAIL restart_t2: got %b expected 0", bus.mul_done);
      end
      tick();
      n_checks++;
      if (bus.mul_done !== 1'b1) begin
         n_errors++; $display("FAIL restart_t3_done: got %b expected 1", bus.mul_done);
      end
      tick();
      $display("test_reset_abort done");
   endtask

   task automatic test_saturation();
      clear_counter();
      drive_load_use();
      for (int c = 0; c < 70000; c++) begin
         tick();
      end
      n_checks++;
      if (bus.stall_cnt !== 16'hFFFF) begin
         n_errors++; $display("FAIL sat_hold: got %h expected ffff", bus.stall_cnt);
      end
      bus.perf_clr = 1'b1;
      tick();
      n_checks++;
      if (bus.stall_cnt !== 16'd0) begin
         n_errors++; $display("FAIL sat_clear_priority: got %h expected 0000", bus.stall_cnt);
      end
      bus.perf_clr = 1'b0;
      tick();
      n_checks++;
      if (bus.stall_cnt !== 16'd1) begin
         n_errors++; $display("FAIL sat_recount: got %h expected 0001", bus.stall_cnt);
      end
      idle_inputs();
      tick();
      $display("test_saturation done");
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();
      test_reset();
      test_load_use();
      test_zero_reg();
      test_mult_mflo();
      test_addu_and_dual();
      test_reset_abort();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
